// File: rtl/aqm_pkg.sv
// Shared definitions for the air-quality monitor: state encoding, default thresholds
// and saturating limit helpers. Hysteresis is enabled by defining AQM_HYSTERESIS_EN.
package aqm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HUMIDIFY = 2'd1,
        PURIFY   = 2'd2
    } aqm_state_t;

    localparam logic [7:0] DEFAULT_HUMIDIFIER_NUM = 8'd30;
    localparam logic [7:0] DEFAULT_PURIFIER_NUM   = 8'd100;
    localparam logic [7:0] DEFAULT_HYST           = 8'd5;

`ifdef AQM_HYSTERESIS_EN
    localparam bit HYST_ENABLED = 1'b1;
`else
    localparam bit HYST_ENABLED = 1'b0;
`endif

    // Limits are clamped to the 8-bit index range instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? 8'h00 : diff[7:0];
    endfunction

endpackage

// File: rtl/aqm_threshold_cmp.sv
// Combinational comparison of the air-quality index against entry and exit limits.
// Exit limits include the hysteresis band only when AQM_HYSTERESIS_EN is defined.
module aqm_threshold_cmp
    import aqm_pkg::*;
#(
    parameter logic [7:0] HUMIDIFIER_NUM = DEFAULT_HUMIDIFIER_NUM,
    parameter logic [7:0] PURIFIER_NUM   = DEFAULT_PURIFIER_NUM,
    parameter logic [7:0] HYST           = DEFAULT_HYST
) (
    input  logic [7:0] air_quality,
    output logic       below_lo,
    output logic       above_hi,
    output logic       clear_lo,
    output logic       clear_hi
);

    // With the band disabled the exit limits collapse onto the entry thresholds.
    localparam logic [7:0] HYST_EFF = HYST_ENABLED ? HYST : 8'd0;
    localparam logic [7:0] LO_EXIT  = sat_add(HUMIDIFIER_NUM, HYST_EFF);
    localparam logic [7:0] HI_EXIT  = sat_sub(PURIFIER_NUM, HYST_EFF);

    assign below_lo = air_quality <  HUMIDIFIER_NUM;
    assign above_hi = air_quality >  PURIFIER_NUM;
    assign clear_lo = air_quality >= LO_EXIT;
    assign clear_hi = air_quality <= HI_EXIT;

endmodule

// File: rtl/air_quality_monitor.sv
// Air-quality controller: drives mutually exclusive humidifier/purifier enables from
// an 8-bit index. Optional hysteresis on exits is enabled by AQM_HYSTERESIS_EN.
module air_quality_monitor
    import aqm_pkg::*;
#(
    parameter logic [7:0] HUMIDIFIER_NUM = DEFAULT_HUMIDIFIER_NUM,
    parameter logic [7:0] PURIFIER_NUM   = DEFAULT_PURIFIER_NUM,
    parameter logic [7:0] HYST           = DEFAULT_HYST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] air_quality,
    output logic       purifier,
    output logic       humidifier
);

    if (HUMIDIFIER_NUM >= PURIFIER_NUM) begin : g_bad_thresholds
        $error("air_quality_monitor: HUMIDIFIER_NUM must be below PURIFIER_NUM");
    end

    if (HYST_ENABLED && (sat_add(HUMIDIFIER_NUM, HYST) > sat_sub(PURIFIER_NUM, HYST))) begin : g_bad_hyst
        $error("air_quality_monitor: hysteresis bands overlap");
    end

    aqm_state_t state;
    aqm_state_t next_state;
    logic       below_lo;
    logic       above_hi;
    logic       clear_lo;
    logic       clear_hi;

    aqm_threshold_cmp #(
        .HUMIDIFIER_NUM(HUMIDIFIER_NUM),
        .PURIFIER_NUM  (PURIFIER_NUM),
        .HYST          (HYST)
    ) u_cmp (
        .air_quality(air_quality),
        .below_lo   (below_lo),
        .above_hi   (above_hi),
        .clear_lo   (clear_lo),
        .clear_hi   (clear_hi)
    );

    // Active states may jump straight to the opposite actuator; they only fall back
    // to IDLE once the index crosses the exit limit.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (below_lo)      next_state = HUMIDIFY;
                else if (above_hi) next_state = PURIFY;
                else               next_state = IDLE;
            end
            HUMIDIFY: begin
                if (above_hi)      next_state = PURIFY;
                else if (clear_lo) next_state = IDLE;
                else               next_state = HUMIDIFY;
            end
            PURIFY: begin
                if (below_lo)      next_state = HUMIDIFY;
                else if (clear_hi) next_state = IDLE;
                else               next_state = PURIFY;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they decode it without extra delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            humidifier <= 1'b0;
            purifier   <= 1'b0;
        end else begin
            state      <= next_state;
            humidifier <= (next_state == HUMIDIFY);
            purifier   <= (next_state == PURIFY);
        end
    end

endmodule

// File: tb/tb_air_quality_monitor.sv
// Directed self-checking bench for air_quality_monitor; the hysteresis steps follow
// whether AQM_HYSTERESIS_EN is defined for the build.
module tb_air_quality_monitor;

    logic       clk;
    logic       rst;
    logic [7:0] air_quality;
    logic       purifier;
    logic       humidifier;

    int total_checks  = 0;
    int passed_checks = 0;

    air_quality_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .air_quality(air_quality),
        .purifier   (purifier),
        .humidifier (humidifier)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic rst_val, input logic [7:0] aq);
        @(negedge clk);
        rst         = rst_val;
        air_quality = aq;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic exp_h, input logic exp_p);
        total_checks++;
        assert (humidifier === exp_h) passed_checks++;
        else $error("[TB] FAIL %s humidifier observed=%b expected=%b", tag, humidifier, exp_h);
        total_checks++;
        assert (purifier === exp_p) passed_checks++;
        else $error("[TB] FAIL %s purifier observed=%b expected=%b", tag, purifier, exp_p);
    endtask

    initial begin
        rst         = 1'b1;
        air_quality = 8'd0;

        apply_stimulus(1'b1, 8'd0);   check_output("reset",        1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd0);   check_output("release_0",    1'b1, 1'b0);

        apply_stimulus(1'b0, 8'd20);  check_output("aq20",         1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd50);  check_output("aq50",         1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd120); check_output("aq120",        1'b0, 1'b1);

        apply_stimulus(1'b0, 8'd50);  check_output("aq50_b",       1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd30);  check_output("eq_lo",        1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd100); check_output("eq_hi",        1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd29);  check_output("lo_minus1",    1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd50);  check_output("aq50_c",       1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd101); check_output("hi_plus1",     1'b0, 1'b1);
        apply_stimulus(1'b0, 8'd255); check_output("aq255",        1'b0, 1'b1);

        apply_stimulus(1'b0, 8'd10);  check_output("jump_10",      1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd200); check_output("jump_200",     1'b0, 1'b1);
        apply_stimulus(1'b0, 8'd10);  check_output("jump_10_b",    1'b1, 1'b0);

        apply_stimulus(1'b0, 8'd150); check_output("pre_rst_150",  1'b0, 1'b1);
        apply_stimulus(1'b1, 8'd150); check_output("mid_rst",      1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd150); check_output("mid_rst_hold", 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd150); check_output("post_rst_150", 1'b0, 1'b1);

`ifdef AQM_HYSTERESIS_EN
        apply_stimulus(1'b0, 8'd20);  check_output("hyst_20",      1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd32);  check_output("hyst_32",      1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd35);  check_output("hyst_35",      1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd120); check_output("hyst_120",     1'b0, 1'b1);
        apply_stimulus(1'b0, 8'd97);  check_output("hyst_97",      1'b0, 1'b1);
        apply_stimulus(1'b0, 8'd95);  check_output("hyst_95",      1'b0, 1'b0);
`else
        apply_stimulus(1'b0, 8'd20);  check_output("base_20",      1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd32);  check_output("base_32",      1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd120); check_output("base_120",     1'b0, 1'b1);
        apply_stimulus(1'b0, 8'd97);  check_output("base_97",      1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
